// File: rtl/ram_port_arbiter.sv
// Shares one synchronous data-RAM port between the CPU memory stage and the
// program loader; CPU has priority, with starvation and lock escapes for the loader.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CPU_PRI  | CPU wins contention; starve counter tracks loader denials
// LD_FORCE | loader wins for exactly one cycle after STARVE_LIMIT denials
// LD_LOCK  | loader wins for as long as ld_lock stays high
module ram_port_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [6:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [6:0]  ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        ld_lock,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic [6:0]  ram_addr,
    output logic        ram_w_en,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_data
);

    localparam int            CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_M1_C = CW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    typedef enum logic [1:0] {
        CPU_PRI  = 2'd0,
        LD_FORCE = 2'd1,
        LD_LOCK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;

    logic cpu_gnt_w;
    logic ld_gnt_w;
    logic rd_issue;

    // Grants are gated by rst_n so every output is 0 the moment reset asserts.
    always_comb begin
        cpu_gnt_w = 1'b0;
        ld_gnt_w  = 1'b0;
        if (rst_n) begin
            if (state_q == CPU_PRI) begin
                cpu_gnt_w = cpu_req;
                ld_gnt_w  = ld_req & ~cpu_req;
            end else begin
                ld_gnt_w  = ld_req;
                cpu_gnt_w = cpu_req & ~ld_req;
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_in   = '0;
        ram_w_en = 1'b0;
        if (cpu_gnt_w) begin
            ram_addr = cpu_addr;
            ram_in   = cpu_wdata;
            ram_w_en = cpu_we;
        end else if (ld_gnt_w) begin
            ram_addr = ld_addr;
            ram_in   = ld_wdata;
            ram_w_en = ld_we;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CPU_PRI: begin
                if (ld_gnt_w && ld_lock) begin
                    state_d = LD_LOCK;
                    cnt_d   = '0;
                end else if (ld_req && !ld_gnt_w) begin
                    if (cnt_q == LIMIT_M1_C) begin
                        state_d = LD_FORCE;
                        cnt_d   = '0;
                    end else if (cnt_q != LIMIT_C) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            LD_FORCE: begin
                state_d = (ld_gnt_w && ld_lock) ? LD_LOCK : CPU_PRI;
                cnt_d   = '0;
            end
            LD_LOCK: begin
                if (!ld_lock) begin
                    state_d = CPU_PRI;
                end
                cnt_d = '0;
            end
            default: begin
                state_d = CPU_PRI;
                cnt_d   = '0;
            end
        endcase
    end

    // Tag pipeline: bit 0 is the newest read, bit RD_LAT-1 lines up with ram_data.
    always_comb begin
        rd_issue     = (cpu_gnt_w & ~cpu_we) | (ld_gnt_w & ~ld_we);
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = rd_issue;
        tag_own_d[0] = rd_issue & ld_gnt_w;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CPU_PRI;
            cnt_q     <= '0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_w;
    assign ld_gnt     = ld_gnt_w;
    assign cpu_stall  = rst_n & cpu_req & ~cpu_gnt_w;
    assign cpu_rvalid = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign ld_rvalid  = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];
    assign cpu_rdata  = cpu_rvalid ? ram_data : '0;
    assign ld_rdata   = ld_rvalid  ? ram_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter against a cycle-level reference model
// with its own memory image and a queue of pending read returns.
module tb_ram_port_arbiter;

    localparam int RD_LAT       = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
    logic [6:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic [6:0]  ram_addr;
    logic        ram_w_en;
    logic [31:0] ram_in, ram_data;

    ram_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_in(ram_in), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: value sampled in the address cycle, presented RD_LAT cycles later.
    logic [31:0] ram_mem [128];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_w_en) ram_mem[ram_addr] <= ram_in;
    end
    assign ram_data = rd_pipe[RD_LAT-1];

    typedef struct {
        int          due;
        bit          own_ld;
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] ref_mem [128];
    int          mode;        // 0 CPU priority, 1 forced loader cycle, 2 loader lock
    int          starve;
    int          cyc;
    int          n_chk;
    int          n_fail;
    bit          last_cpu_gnt, last_ld_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h required 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
        chk({tag, "_ld_gnt"},     32'(ld_gnt),     32'd0);
        chk({tag, "_cpu_stall"},  32'(cpu_stall),  32'd0);
        chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_ld_rvalid"},  32'(ld_rvalid),  32'd0);
        chk({tag, "_cpu_rdata"},  cpu_rdata,       32'd0);
        chk({tag, "_ld_rdata"},   ld_rdata,        32'd0);
        chk({tag, "_ram_w_en"},   32'(ram_w_en),   32'd0);
        chk({tag, "_ram_addr"},   32'(ram_addr),   32'd0);
        chk({tag, "_ram_in"},     ram_in,          32'd0);
    endtask

    // One clock cycle: inputs are already applied; check, then advance the model at the edge.
    task automatic step();
        bit          eg_c, eg_l, rv_c, rv_l, e_we;
        logic [6:0]  e_addr;
        logic [31:0] e_in, rd_c, rd_l;
        ret_t        r;
        #1;
        if (mode == 0) begin
            eg_c = cpu_req;
            eg_l = ld_req && !cpu_req;
        end else begin
            eg_l = ld_req;
            eg_c = cpu_req && !ld_req;
        end
        e_we   = (eg_c && cpu_we) || (eg_l && ld_we);
        e_addr = eg_c ? cpu_addr  : (eg_l ? ld_addr  : 7'd0);
        e_in   = eg_c ? cpu_wdata : (eg_l ? ld_wdata : 32'd0);
        rv_c = 0; rv_l = 0; rd_c = 0; rd_l = 0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.own_ld) begin rv_l = 1; rd_l = r.data; end
            else          begin rv_c = 1; rd_c = r.data; end
        end
        chk("cpu_gnt",    32'(cpu_gnt),    32'(eg_c));
        chk("ld_gnt",     32'(ld_gnt),     32'(eg_l));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !eg_c));
        chk("ram_w_en",   32'(ram_w_en),   32'(e_we));
        chk("ram_addr",   32'(ram_addr),   32'(e_addr));
        chk("ram_in",     ram_in,          e_in);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rv_c));
        chk("cpu_rdata",  cpu_rdata,       rd_c);
        chk("ld_rvalid",  32'(ld_rvalid),  32'(rv_l));
        chk("ld_rdata",   ld_rdata,        rd_l);
        last_cpu_gnt = eg_c;
        last_ld_gnt  = eg_l;
        @(posedge clk);
        if (eg_c) begin
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else ret_q.push_back('{cyc + RD_LAT, 1'b0, ref_mem[cpu_addr]});
        end
        if (eg_l) begin
            if (ld_we) ref_mem[ld_addr] = ld_wdata;
            else ret_q.push_back('{cyc + RD_LAT, 1'b1, ref_mem[ld_addr]});
        end
        case (mode)
            0: begin
                if (eg_l && ld_lock) begin
                    mode = 2; starve = 0;
                end else if (ld_req && !eg_l) begin
                    starve++;
                    if (starve >= STARVE_LIMIT) begin mode = 1; starve = 0; end
                end else begin
                    starve = 0;
                end
            end
            1: begin mode = (eg_l && ld_lock) ? 2 : 0; starve = 0; end
            default: begin if (!ld_lock) mode = 0; starve = 0; end
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ld, stall_cnt, addr;
        n_chk = 0; n_fail = 0; cyc = 0; mode = 0; starve = 0;
        idle_inputs();
        cpu_req = 1; ld_req = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        idle_inputs();
        rst_n = 1;

        // Preload every word through the loader, with the directed values planted.
        for (int a = 0; a < 128; a++) begin
            ld_req = 1; ld_we = 1; ld_addr = 7'(a);
            ld_wdata = (a == 5) ? 32'hDEADBEEF : (a == 16) ? 32'h11 : (a == 32) ? 32'h22 : $urandom;
            step();
        end
        idle_inputs();
        step();

        // Single CPU read of 0x05.
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05;
        step();
        chk("single_rd_gnt", 32'(last_cpu_gnt), 32'd1);
        cpu_req = 0;
        repeat (RD_LAT + 1) step();

        // Contention: both held; loader must win exactly the fifth cycle.
        first_ld = -1; stall_cnt = 0;
        cpu_req = 1; cpu_addr = 7'($urandom); ld_req = 1; ld_we = 0; ld_addr = 7'($urandom);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (ld_gnt && first_ld < 0) first_ld = i;
            if (cpu_stall) stall_cnt++;
            step();
        end
        chk("contention_first_ld", 32'(first_ld), 32'd4);
        chk("contention_stalls", 32'(stall_cnt), 32'd1);
        idle_inputs();
        repeat (RD_LAT + 1) step();

        // Locked loader write burst to 0x00..0x03 under CPU pressure.
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h40;
        ld_req = 1; ld_we = 1; ld_lock = 1; addr = 0; ld_addr = 0; ld_wdata = $urandom;
        for (int i = 0; i < 20 && addr < 4; i++) begin
            step();
            if (last_ld_gnt) begin
                addr++; ld_addr = 7'(addr); ld_wdata = $urandom;
            end
        end
        chk("lock_burst_done", 32'(addr), 32'd4);
        ld_req = 0; ld_lock = 0;
        repeat (3) step();
        idle_inputs();
        repeat (RD_LAT + 1) step();

        // Interleaved reads: CPU 0x10 then loader 0x20 back to back.
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h10;
        step();
        cpu_req = 0; ld_req = 1; ld_we = 0; ld_addr = 7'h20;
        step();
        ld_req = 0;
        repeat (RD_LAT + 1) step();

        // Reset while a CPU read is in flight.
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05;
        step();
        cpu_req = 1; ld_req = 1;
        rst_n = 0;
        #1 chk_all_zero("rst_mid");
        ret_q.delete(); mode = 0; starve = 0;
        repeat (2) @(negedge clk);
        idle_inputs();
        rst_n = 1;
        repeat (RD_LAT + 2) step();

        // Loader write with no CPU contention.
        ld_req = 1; ld_we = 1; ld_addr = 7'h7F; ld_wdata = 32'hCAFE0001;
        step();
        idle_inputs();
        repeat (RD_LAT + 1) step();

        // Randomized traffic obeying hold-until-granted.
        last_cpu_gnt = 0; last_ld_gnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!cpu_req || last_cpu_gnt) begin
                cpu_req = ($urandom_range(0, 99) < 60);
                cpu_we = $urandom_range(0, 1); cpu_addr = 7'($urandom); cpu_wdata = $urandom;
            end
            if (!ld_req || last_ld_gnt) begin
                ld_req = ($urandom_range(0, 99) < 50);
                ld_we = $urandom_range(0, 1); ld_addr = 7'($urandom); ld_wdata = $urandom;
            end
            if ($urandom_range(0, 99) < 10) ld_lock = ~ld_lock;
            step();
        end
        idle_inputs();
        repeat (RD_LAT + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
